// File: rtl/adc_capture_bank.sv
// Multi-chip serial ADC capture bank: synchronizes per-chip sclk/sdo, shifts frames
// MSB-first on sclk falling edges and latches complete frames into holding registers.
module adc_capture_bank #(
    parameter int NUM_CHIPS   = 2,
    parameter int CH_PER_CHIP = 4,
    parameter int ADC_BITS    = 16,
    localparam int SEL_W      = ((NUM_CHIPS * CH_PER_CHIP) > 1) ? $clog2(NUM_CHIPS * CH_PER_CHIP) : 1
) (
    input  logic                               clk,
    input  logic                               adc_reg_reset,
    input  logic [NUM_CHIPS-1:0]               adc_sclk,
    input  logic [NUM_CHIPS*CH_PER_CHIP-1:0]   adc_sdo,
    input  logic [NUM_CHIPS-1:0]               adc_arm,
    input  logic                               adc_clear,
    input  logic [SEL_W-1:0]                   adc_mux_sel,
    output logic [ADC_BITS-1:0]                adc_reg,
    output logic [NUM_CHIPS-1:0]               adc_done,
    output logic [NUM_CHIPS-1:0]               adc_overrun
);

    localparam int NUM_LANES = NUM_CHIPS * CH_PER_CHIP;
    localparam int CNT_W     = $clog2(ADC_BITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    logic [NUM_CHIPS-1:0] sclk_s1, sclk_s2, sclk_d;
    logic [NUM_LANES-1:0] sdo_s1, sdo_s2, sdo_d;
    logic [NUM_CHIPS-1:0] fall;

    state_t              state [NUM_CHIPS];
    logic [CNT_W-1:0]    cnt   [NUM_CHIPS];
    logic [ADC_BITS-1:0] shift [NUM_LANES];
    logic [ADC_BITS-1:0] hold  [NUM_LANES];

    // sdo takes the same three flops as sclk so the sampled bit lines up with the edge
    always_ff @(posedge clk or posedge adc_reg_reset) begin
        if (adc_reg_reset) begin
            sclk_s1 <= '0;
            sclk_s2 <= '0;
            sclk_d  <= '0;
            sdo_s1  <= '0;
            sdo_s2  <= '0;
            sdo_d   <= '0;
        end else begin
            sclk_s1 <= adc_sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            sdo_s1  <= adc_sdo;
            sdo_s2  <= sdo_s1;
            sdo_d   <= sdo_s2;
        end
    end

    assign fall = sclk_d & ~sclk_s2;

    always_ff @(posedge clk or posedge adc_reg_reset) begin
        if (adc_reg_reset) begin
            adc_done    <= '0;
            adc_overrun <= '0;
            for (int unsigned c = 0; c < NUM_CHIPS; c++) begin
                state[c] <= IDLE;
                cnt[c]   <= '0;
            end
            for (int unsigned i = 0; i < NUM_LANES; i++) begin
                shift[i] <= '0;
                hold[i]  <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CHIPS; c++) begin
                if (adc_clear) begin
                    state[c]       <= IDLE;
                    cnt[c]         <= '0;
                    adc_done[c]    <= 1'b0;
                    adc_overrun[c] <= 1'b0;
                    for (int unsigned k = 0; k < CH_PER_CHIP; k++) begin
                        shift[c*CH_PER_CHIP+k] <= '0;
                        hold[c*CH_PER_CHIP+k]  <= '0;
                    end
                end else if (adc_arm[c]) begin
                    // arm restarts from any state and swallows a coincident edge
                    state[c]    <= CAPTURE;
                    cnt[c]      <= '0;
                    adc_done[c] <= 1'b0;
                    for (int unsigned k = 0; k < CH_PER_CHIP; k++)
                        shift[c*CH_PER_CHIP+k] <= '0;
                end else begin
                    case (state[c])
                        CAPTURE: begin
                            if (fall[c]) begin
                                cnt[c] <= cnt[c] + CNT_W'(1);
                                for (int unsigned k = 0; k < CH_PER_CHIP; k++)
                                    shift[c*CH_PER_CHIP+k] <=
                                        {shift[c*CH_PER_CHIP+k][ADC_BITS-2:0], sdo_d[c*CH_PER_CHIP+k]};
                                if (cnt[c] == CNT_W'(ADC_BITS - 1)) begin
                                    for (int unsigned k = 0; k < CH_PER_CHIP; k++)
                                        hold[c*CH_PER_CHIP+k] <=
                                            {shift[c*CH_PER_CHIP+k][ADC_BITS-2:0], sdo_d[c*CH_PER_CHIP+k]};
                                    adc_done[c] <= 1'b1;
                                    state[c]    <= DONE;
                                end
                            end
                        end
                        default: begin
                            if (fall[c])
                                adc_overrun[c] <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge adc_reg_reset) begin
        if (adc_reg_reset)
            adc_reg <= '0;
        else if (32'(adc_mux_sel) < NUM_LANES)
            adc_reg <= hold[adc_mux_sel];
        else
            adc_reg <= '0;
    end

endmodule

// File: tb/tb_adc_capture_bank.sv
// Directed bench for adc_capture_bank: default build plus a 3-chip/2-lane/12-bit build.
module tb_adc_capture_bank;

    logic        clk = 1'b0;
    logic        adc_reg_reset;

    logic [1:0]  sclk;
    logic [7:0]  sdo;
    logic [1:0]  arm;
    logic        clr;
    logic [2:0]  sel;
    logic [15:0] reg_o;
    logic [1:0]  done_o;
    logic [1:0]  ovr_o;

    logic [2:0]  sclk2;
    logic [5:0]  sdo2;
    logic [2:0]  arm2;
    logic        clr2;
    logic [2:0]  sel2;
    logic [11:0] reg2_o;
    logic [2:0]  done2_o;
    logic [2:0]  ovr2_o;

    logic [15:0] word [8];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_capture_bank u_dut (
        .clk(clk), .adc_reg_reset(adc_reg_reset), .adc_sclk(sclk), .adc_sdo(sdo),
        .adc_arm(arm), .adc_clear(clr), .adc_mux_sel(sel),
        .adc_reg(reg_o), .adc_done(done_o), .adc_overrun(ovr_o)
    );

    adc_capture_bank #(.NUM_CHIPS(3), .CH_PER_CHIP(2), .ADC_BITS(12)) u_dut2 (
        .clk(clk), .adc_reg_reset(adc_reg_reset), .adc_sclk(sclk2), .adc_sdo(sdo2),
        .adc_arm(arm2), .adc_clear(clr2), .adc_mux_sel(sel2),
        .adc_reg(reg2_o), .adc_done(done2_o), .adc_overrun(ovr2_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm_pulse(input logic [1:0] mask);
        arm = mask;
        tick(1);
        arm = 2'b00;
        tick(1);
    endtask

    // each sclk period: 4 clk high, 4 clk low; sdo changes only at the start of the high phase
    task automatic run_edges(input logic [1:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < 8; l++) sdo[l] = word[l][15 - (i % 16)];
            sclk = mask;
            tick(4);
            sclk = 2'b00;
            tick(4);
        end
        tick(2);
    endtask

    task automatic run_edges2(input logic [11:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            sdo2[5] = w[11 - (i % 12)];
            sclk2 = 3'b100;
            tick(4);
            sclk2 = 3'b000;
            tick(4);
        end
        tick(2);
    endtask

    task automatic read_sel(input logic [2:0] s);
        sel = s;
        tick(1);
    endtask

    initial begin
        sclk = '0; sdo = '0; arm = '0; clr = 1'b0; sel = '0;
        sclk2 = '0; sdo2 = '0; arm2 = '0; clr2 = 1'b0; sel2 = '0;
        for (int l = 0; l < 8; l++) word[l] = '0;
        adc_reg_reset = 1'b1;
        #23;
        check("reset_reg",      32'(reg_o),   32'h0);
        check("reset_done",     32'(done_o),  32'h0);
        check("reset_overrun",  32'(ovr_o),   32'h0);
        check("reset_reg_b",    32'(reg2_o),  32'h0);
        check("reset_done_b",   32'(done2_o), 32'h0);
        adc_reg_reset = 1'b0;
        tick(3);

        // single chip0 frame on lane a
        word[0] = 16'hA5C3;
        arm_pulse(2'b01);
        run_edges(2'b01, 16);
        check("t1_done",    32'(done_o), 32'h1);
        check("t1_overrun", 32'(ovr_o),  32'h0);
        read_sel(3'd0);
        check("t1_sel0", 32'(reg_o), 32'hA5C3);
        read_sel(3'd1);
        check("t1_sel1", 32'(reg_o), 32'h0);

        // concurrent frames on both chips
        word[0] = 16'h0000; word[3] = 16'h1234; word[6] = 16'hFFFF;
        arm_pulse(2'b11);
        check("t2_done_after_arm", 32'(done_o), 32'h0);
        run_edges(2'b11, 16);
        check("t2_done", 32'(done_o), 32'h3);
        read_sel(3'd3);
        check("t2_sel3", 32'(reg_o), 32'h1234);
        read_sel(3'd6);
        check("t2_sel6", 32'(reg_o), 32'hFFFF);
        read_sel(3'd0);
        check("t2_sel0", 32'(reg_o), 32'h0);

        // chip1 partial frame, re-arm, full frame
        word[4] = 16'hAAAA;
        arm_pulse(2'b10);
        run_edges(2'b10, 8);
        check("t3_done_partial", 32'(done_o), 32'h1);
        read_sel(3'd4);
        check("t3_sel4_partial", 32'(reg_o), 32'h0);
        word[4] = 16'h00FF;
        arm_pulse(2'b10);
        run_edges(2'b10, 16);
        check("t3_done", 32'(done_o), 32'h3);
        read_sel(3'd4);
        check("t3_sel4", 32'(reg_o), 32'h00FF);

        // 17 edges: 17th is an overrun, then clear
        word[0] = 16'h5A5A;
        arm_pulse(2'b01);
        run_edges(2'b01, 17);
        check("t4_done",    32'(done_o), 32'h3);
        check("t4_overrun", 32'(ovr_o),  32'h1);
        read_sel(3'd0);
        check("t4_sel0", 32'(reg_o), 32'h5A5A);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(1);
        check("t4_clr_done",    32'(done_o), 32'h0);
        check("t4_clr_overrun", 32'(ovr_o),  32'h0);
        check("t4_clr_reg",     32'(reg_o),  32'h0);

        // reset mid-capture, then edges without arm
        word[0] = 16'h1357;
        arm_pulse(2'b01);
        run_edges(2'b01, 16);
        tick(1);
        check("t5_sel0", 32'(reg_o), 32'h1357);
        word[0] = 16'hFFFF;
        arm_pulse(2'b01);
        run_edges(2'b01, 10);
        check("t5_no_partial", 32'(reg_o), 32'h1357);
        #3;
        adc_reg_reset = 1'b1;
        #1;
        check("t5_async_reg", 32'(reg_o), 32'h0);
        tick(1);
        adc_reg_reset = 1'b0;
        tick(2);
        run_edges(2'b01, 16);
        check("t5_overrun", 32'(ovr_o),  32'h1);
        check("t5_done",    32'(done_o), 32'h0);
        check("t5_sel0",    32'(reg_o),  32'h0);

        // alternate geometry: chip2 lane1 = index 5
        arm2 = 3'b100;
        tick(1);
        arm2 = 3'b000;
        tick(1);
        run_edges2(12'hABC, 12);
        check("t6_done", 32'(done2_o), 32'h4);
        sel2 = 3'd5;
        tick(1);
        check("t6_sel5", 32'(reg2_o), 32'hABC);
        sel2 = 3'd7;
        tick(1);
        check("t6_sel7", 32'(reg2_o), 32'h0);
        sel2 = 3'd4;
        tick(1);
        check("t6_sel4", 32'(reg2_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
